bcd_countdown_timer: RTL

Parametrised BCD countdown timer for the egg-timer datapath. It holds an MM…M:SS value with a configurable number of minute digits and decrements it once per prescaled tick, with a built-in clock divider. It also supports pause, load validation, a one-shot done pulse and an optional auto-reload mode. It replaces the fixed two-digit seconds decrementer and sits between the keypad/load logic and the display driver.

---
 rtl/bcd_countdown_timer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: MM..M:SS value decremented once per prescaled tick,
// with load validation, pause, one-shot done pulse and optional auto-reload.
module bcd_countdown_timer #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int MIN_DIGITS = 2,
    localparam int W         = 4 * (MIN_DIGITS + 2)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         writeEnable,
    input  logic [W-1:0] inputTime,
    input  logic         runEnable,
    input  logic         reloadMode,
    output logic [W-1:0] outputTime,
    output logic         isZero,
    output logic         done,
    output logic         loadError
);

    localparam int NDIG = MIN_DIGITS + 2;
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [W-1:0]  time_q, time_d;
    logic [W-1:0]  reload_q, reload_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          is_zero_q, is_zero_d;
    logic          done_q, done_d;
    logic          load_err_q, load_err_d;

    logic [W-1:0]  dec_val;
    logic          dec_zero;
    logic          load_valid;
    logic          halted;
    logic          advance;
    logic          tick;

    // Borrow ripples upward from seconds-ones; seconds-tens wraps to 5, all
    // other digits to 9. A zero value never reaches this path on a tick.
    // NOTE: blocking assignments are correct here; borrow is a combinational
    // chain evaluated in loop order, and every variable gets a default first.
    always_comb begin
        logic       borrow;
        logic [3:0] digit;
        dec_val = time_q;
        borrow  = 1'b1;
        digit   = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            digit = time_q[4*i +: 4];
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digit - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    assign dec_zero = (dec_val == '0);

    always_comb begin
        logic [3:0] digit;
        load_valid = 1'b1;
        digit      = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            digit = inputTime[4*i +: 4];
            if (digit > 4'd9) load_valid = 1'b0;
            if ((i == 1) && (digit > 4'd5)) load_valid = 1'b0;
        end
    end

    // Halted blocks the prescaler so a finished count sits still until a load
    // or until auto-reload becomes possible.
    assign halted  = is_zero_q && (!reloadMode || (reload_q == '0));
    assign advance = runEnable && !halted;
    assign tick    = advance && (presc_q == PRESC_LAST);

    always_comb begin
        time_d     = time_q;
        reload_d   = reload_q;
        presc_d    = presc_q;
        is_zero_d  = is_zero_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (writeEnable) begin
            if (load_valid) begin
                time_d    = inputTime;
                reload_d  = inputTime;
                presc_d   = '0;
                is_zero_d = (inputTime == '0);
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            presc_d = '0;
            if (!is_zero_q) begin
                time_d    = dec_val;
                is_zero_d = dec_zero;
                done_d    = dec_zero;
            end else begin
                time_d    = reload_q;
                is_zero_d = 1'b0;
            end
        end else if (advance) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            time_q     <= '0;
            reload_q   <= '0;
            presc_q    <= '0;
            is_zero_q  <= 1'b1;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            time_q     <= time_d;
            reload_q   <= reload_d;
            presc_q    <= presc_d;
            is_zero_q  <= is_zero_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign outputTime = time_q;
    assign isZero     = is_zero_q;
    assign done       = done_q;
    assign loadError  = load_err_q;

endmodule
